i2s_master_tx: RTL and testbench
================================

# i2s_master_tx

I2S bus master and stereo transmitter: generates BCLK and LRCLK from the system clock and serializes 24-bit left/right sample pairs MSB-first in Philips I2S format. It is the counterpart of the slave-side I2S receive path and drives a codec's DAC input, or the FPGA's own I2S receiver in loopback. Samples arrive over a valid/ready handshake into a one-entry holding buffer. Frames with no sample available are zero-filled and flagged.

## Interface
- DATA_W, 24, sample width per channel; must satisfy DATA_W <= SLOT_W-1
- SLOT_W, 32, BCLK periods per channel slot
- BCLK_DIV, 2, clk cycles per BCLK half-period (>=1)
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request; level-sensitive
- left_in  in  DATA_W  left sample, two's complement
- right_in  in  DATA_W  right sample
- in_valid  in  1  sample pair valid
- in_ready  out  1  holding buffer empty; reset 0
- bclk  out  1  bit clock; reset 0
- lrclk  out  1  word select, 0 = left, 1 = right; reset 0
- sdout  out  1  serial data; reset 0
- frame_start  out  1  one-clk pulse on first cycle of each frame; reset 0
- underrun  out  1  one-clk pulse when a frame starts with the buffer empty; reset 0

## Operation
- All outputs are registered. Reset asynchronously clears all state: hold_full=0, state IDLE, all counters 0. in_ready reads 1 from the first clk after reset release.
- Holding buffer, one entry:
  - in_ready = ~hold_full.
  - An accept occurs when in_valid && in_ready at a posedge; left_in/right_in are captured and hold_full is set.
- State IDLE:
  - bclk=0, lrclk=0, sdout=0.
  - When enable=1 is sampled, go to RUN and start a frame on the next cycle.
- State RUN, counters:
  - div_cnt runs 0..BCLK_DIV-1.
  - bclk toggles when div_cnt wraps.
  - bit_cnt runs 0..SLOT_W-1 and advances on each bclk falling transition.
  - ch toggles when bit_cnt wraps.
- Frame = left slot (lrclk=0) then right slot (lrclk=1), 2*SLOT_W bit periods.
- lrclk and sdout change only together with a bclk 1->0 transition, or at frame start where bclk is already 0.
- Slot bit period k:
  - k=0: sdout=0 (I2S one-bit delay).
  - k=1..DATA_W: sdout = word[DATA_W-k].
  - k>DATA_W: sdout=0.
- Frame load, in the cycle that starts a frame:
  - If hold_full: the frame shift registers take the held pair, hold_full clears, and frame_start pulses.
  - Else: the frame transmits zeros, and frame_start and underrun both pulse.
- Simultaneous accept and frame start with the buffer empty: the new pair goes to the buffer and is sent next frame; the current frame underruns.
- With the buffer full, in_ready=0 during the load cycle. in_ready returns to 1 on the following cycle.
- enable=0 during RUN: the current frame completes. At the end of the last right-slot bit period, go to IDLE (bclk=0, lrclk=0, sdout=0). The held pair is retained.
- enable=1 at the end of a frame: the next frame starts with no gap.
- Reset mid-frame: outputs return to reset values immediately. The buffer contents are discarded.

## Timing
- Bit period = 2*BCLK_DIV clk; frame = 4*SLOT_W*BCLK_DIV clk. Defaults give 4 clk per bit and 256 clk per frame.
- Start-up, with enable sampled 1 in IDLE at edge T:
  - At T+1: frame_start=1, lrclk=0, bclk=0, sdout=0.
  - bclk rises at T+1+BCLK_DIV and falls at T+1+2*BCLK_DIV.
  - The left MSB is on sdout from T+1+2*BCLK_DIV.
- A receiver samples sdout on bclk rising edges; sdout is stable for BCLK_DIV clk either side of each rising edge.
- lrclk toggles at the start of bit period 0 of each slot, one bit period before that slot's MSB.
- Accept-to-wire latency: the pair is sent in the next frame that starts after the accept cycle.

## Test plan
- Reset: hold rst_n=0 with enable=1 and in_valid=1 -> bclk=lrclk=sdout=0, in_ready=0, no pulses; in_ready=1 one clk after release.
- Single frame: accept left=24'hABCDEF, right=24'h123456, then enable=1 -> on bclk rising edges the left slot reads 0, 1010_1011_1100_1101_1110_1111, then seven 0s; the right slot reads 0, 0001_0010_0011_0100_0101_0110, then seven 0s; lrclk low for 32 bits, then high for 32 bits.
- Underrun: enable=1 with in_valid=0 -> at the first frame, frame_start and underrun pulse together, and sdout stays 0 for 256 clk.
- Streaming: in_valid held at 1 with incrementing data -> exactly one accept per frame, no underrun after the first frame, in_ready low for 255 of 256 clk, samples on the wire in order.
- Stop: drop enable at bit 10 of the left slot -> the frame completes, then IDLE with outputs 0 and no further frame_start; the buffered pair is sent first after re-enable.
- Mid-frame reset: pulse rst_n low during the right slot -> all outputs 0 in the same cycle; the pending buffer is discarded and underrun fires on the next enabled frame.

Source files
------------

// File: rtl/i2s_master_tx.sv
// I2S master/stereo transmitter: derives BCLK/LRCLK from clk and shifts DATA_W-bit pairs MSB-first, Philips format.
// One-entry holding buffer; a pair goes out in the first frame starting after its accept; in_ready low while the buffer is full.
module i2s_master_tx #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdout,
  output logic              frame_start,
  output logic              underrun
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]        r_state;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_ch;
  logic              r_bclk;
  logic              r_lrclk;
  logic              r_sdout;
  logic              r_frame_start;
  logic              r_underrun;
  logic              r_in_ready;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold_l;
  logic [DATA_W-1:0] r_hold_r;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_right;

  logic w_accept;
  logic w_div_wrap;
  logic w_bclk_fall;
  logic w_slot_end;
  logic w_frame_end;
  logic w_load;
  logic w_stop;

  assign w_accept    = in_valid & r_in_ready;
  assign w_div_wrap  = (r_state == ST_RUN) && (r_div_cnt == DIV_LAST);
  assign w_bclk_fall = w_div_wrap && r_bclk;
  assign w_slot_end  = w_bclk_fall && (r_bit_cnt == BIT_LAST);
  assign w_frame_end = w_slot_end && r_ch;
  assign w_load      = (r_state == ST_START) || (w_frame_end && enable);
  assign w_stop      = w_frame_end && !enable;

  // in_ready drops on the accept edge itself but only recovers the cycle after a drain,
  // so a second accept can never land on a full buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_in_ready  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold_l    <= left_in;
        r_hold_r    <= right_in;
        r_hold_full <= 1'b1;
      end else if (w_load && r_hold_full) begin
        r_hold_full <= 1'b0;
      end
      r_in_ready <= ~r_hold_full & ~w_accept;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_div_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_ch          <= 1'b0;
      r_bclk        <= 1'b0;
      r_lrclk       <= 1'b0;
      r_sdout       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_shift       <= '0;
      r_right       <= '0;
    end else begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      if (w_load) begin
        // Frame start: bclk is low here, so lrclk/sdout may legally reset with it.
        r_state       <= ST_RUN;
        r_div_cnt     <= '0;
        r_bit_cnt     <= '0;
        r_ch          <= 1'b0;
        r_bclk        <= 1'b0;
        r_lrclk       <= 1'b0;
        r_sdout       <= 1'b0;
        r_frame_start <= 1'b1;
        r_underrun    <= ~r_hold_full;
        r_shift       <= r_hold_full ? r_hold_l : '0;
        r_right       <= r_hold_full ? r_hold_r : '0;
      end else if (w_stop) begin
        r_state   <= ST_IDLE;
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
        r_ch      <= 1'b0;
        r_bclk    <= 1'b0;
        r_lrclk   <= 1'b0;
        r_sdout   <= 1'b0;
      end else if (r_state == ST_RUN) begin
        if (w_div_wrap) begin
          r_div_cnt <= '0;
          r_bclk    <= ~r_bclk;
        end else begin
          r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
        if (w_slot_end) begin
          // Left-to-right slot change; the right-to-left one is a frame end handled above.
          r_bit_cnt <= '0;
          r_ch      <= 1'b1;
          r_lrclk   <= 1'b1;
          r_sdout   <= 1'b0;
          r_shift   <= r_right;
        end else if (w_bclk_fall) begin
          // Shifting in zeros makes bit periods past DATA_W come out as 0.
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          r_sdout   <= r_shift[DATA_W-1];
          r_shift   <= r_shift << 1;
        end
      end else if (r_state == ST_IDLE && enable) begin
        r_state <= ST_START;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign bclk        = r_bclk;
  assign lrclk       = r_lrclk;
  assign sdout       = r_sdout;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Directed bench for i2s_master_tx at default parameters (4 clk per bit, 256 clk per frame).
module tb_i2s_master_tx;
  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [23:0] left_in;
  logic [23:0] right_in;
  logic        in_valid;
  logic        in_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdout;
  logic        frame_start;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  logic        stream_on = 1'b0;
  int          n_acc     = 0;

  logic [63:0] cap_bits;
  logic [63:0] cap_lr;
  int          cap_nrise;
  int          cap_first;
  int          cap_ir_hi;
  int          cap_fs;
  int          cap_ur;
  int          cap_glitch;

  i2s_master_tx #(.DATA_W(24), .SLOT_W(32), .BCLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .left_in(left_in), .right_in(right_in), .in_valid(in_valid), .in_ready(in_ready),
    .bclk(bclk), .lrclk(lrclk), .sdout(sdout),
    .frame_start(frame_start), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] frame_word(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'd0, 1'b0, r, 7'd0};
  endfunction

  // One clock; inputs change and outputs are read 1 ns after the rising edge.
  task automatic tick();
    logic acc;
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (stream_on && acc) begin
      n_acc++;
      left_in  = 24'h100000 + 24'(n_acc);
      right_in = 24'h200000 + 24'(n_acc);
    end
  endtask

  // Records one 256-clk frame window starting at the current (frame_start) sample.
  task automatic capture(input int drop_at);
    logic pb, pl, ps;
    cap_bits = '0; cap_lr = '0; cap_nrise = 0; cap_first = -1;
    cap_ir_hi = int'(in_ready); cap_fs = int'(frame_start); cap_ur = int'(underrun);
    cap_glitch = 0;
    pb = bclk; pl = lrclk; ps = sdout;
    for (int s = 1; s < 256; s++) begin
      if (s == drop_at) enable = 1'b0;
      tick();
      cap_ir_hi += int'(in_ready);
      cap_fs    += int'(frame_start);
      cap_ur    += int'(underrun);
      if (!pb && bclk) begin
        if (cap_nrise < 64) begin
          cap_bits[63-cap_nrise] = sdout;
          cap_lr[63-cap_nrise]   = lrclk;
        end
        if (cap_first < 0) cap_first = s;
        cap_nrise++;
      end
      if ((sdout !== ps || lrclk !== pl) && !(pb && !bclk)) cap_glitch++;
      pb = bclk; pl = lrclk; ps = sdout;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b1;
    left_in = 24'h5A5A5A; right_in = 24'hA5A5A5;
    repeat (3) tick();
    total++; if ({bclk, lrclk, sdout} !== 3'b000) begin bad++; $display("FAIL reset_outs: got %b want 000", {bclk, lrclk, sdout}); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if ({frame_start, underrun} !== 2'b00) begin bad++; $display("FAIL reset_pulses: got %b want 00", {frame_start, underrun}); end
    rst_n = 1'b1; enable = 1'b0; in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL release_in_ready0: got %b want 0", in_ready); end
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready1: got %b want 1", in_ready); end
  endtask

  task automatic test_single_frame();
    logic [63:0] exp_bits;
    logic [63:0] exp_lr;
    exp_bits = {1'b0, 24'hABCDEF, 7'd0, 1'b0, 24'h123456, 7'd0};
    exp_lr   = {32'h0000_0000, 32'hFFFF_FFFF};
    left_in = 24'hABCDEF; right_in = 24'h123456; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sf_full: in_ready got %b want 0", in_ready); end
    enable = 1'b1;
    tick();
    enable = 1'b0;
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL sf_no_early_start: got %b want 0", frame_start); end
    tick();
    total++; if ({frame_start, underrun, bclk, lrclk, sdout, in_ready} !== 6'b100000) begin
      bad++; $display("FAIL sf_start: fs,ur,bclk,lr,sd,rdy got %b want 100000", {frame_start, underrun, bclk, lrclk, sdout, in_ready});
    end
    capture(-1);
    total++; if (cap_bits !== exp_bits) begin bad++; $display("FAIL sf_bits: got %h want %h", cap_bits, exp_bits); end
    total++; if (cap_lr !== exp_lr) begin bad++; $display("FAIL sf_lrclk: got %h want %h", cap_lr, exp_lr); end
    total++; if (cap_nrise !== 64) begin bad++; $display("FAIL sf_nrise: got %0d want 64", cap_nrise); end
    total++; if (cap_first !== 2) begin bad++; $display("FAIL sf_first_rise: got %0d want 2", cap_first); end
    total++; if (cap_glitch !== 0) begin bad++; $display("FAIL sf_glitch: got %0d want 0", cap_glitch); end
    total++; if (cap_ir_hi !== 255) begin bad++; $display("FAIL sf_in_ready: high %0d want 255", cap_ir_hi); end
    total++; if ({cap_fs, cap_ur} !== {32'd1, 32'd0}) begin bad++; $display("FAIL sf_pulses: fs %0d ur %0d want 1 0", cap_fs, cap_ur); end
    tick();
    total++; if ({frame_start, bclk, lrclk, sdout} !== 4'b0000) begin bad++; $display("FAIL sf_idle: got %b want 0000", {frame_start, bclk, lrclk, sdout}); end
  endtask

  task automatic test_underrun();
    in_valid = 1'b0; enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    total++; if ({frame_start, underrun} !== 2'b11) begin bad++; $display("FAIL ur_pulse: got %b want 11", {frame_start, underrun}); end
    capture(-1);
    total++; if (cap_bits !== 64'd0) begin bad++; $display("FAIL ur_bits: got %h want 0", cap_bits); end
    total++; if (cap_nrise !== 64) begin bad++; $display("FAIL ur_nrise: got %0d want 64", cap_nrise); end
    total++; if ({cap_fs, cap_ur} !== {32'd1, 32'd1}) begin bad++; $display("FAIL ur_counts: fs %0d ur %0d want 1 1", cap_fs, cap_ur); end
    tick();
  endtask

  task automatic test_streaming();
    logic [63:0] exp_bits;
    n_acc = 0; stream_on = 1'b1;
    left_in = 24'h100000; right_in = 24'h200000; in_valid = 1'b1; enable = 1'b1;
    tick();
    tick();
    for (int f = 0; f < 3; f++) begin
      exp_bits = frame_word(24'h100000 + 24'(f), 24'h200000 + 24'(f));
      total++; if ({frame_start, underrun} !== 2'b10) begin bad++; $display("FAIL st_start%0d: got %b want 10", f, {frame_start, underrun}); end
      capture(-1);
      total++; if (cap_bits !== exp_bits) begin bad++; $display("FAIL st_bits%0d: got %h want %h", f, cap_bits, exp_bits); end
      total++; if ({cap_fs, cap_ur} !== {32'd1, 32'd0}) begin bad++; $display("FAIL st_pulses%0d: fs %0d ur %0d want 1 0", f, cap_fs, cap_ur); end
      total++; if (cap_ir_hi !== 1) begin bad++; $display("FAIL st_in_ready%0d: high %0d want 1", f, cap_ir_hi); end
      total++; if (n_acc !== f + 2) begin bad++; $display("FAIL st_accepts%0d: got %0d want %0d", f, n_acc, f + 2); end
      tick();
    end
  endtask

  task automatic test_stop();
    int fs_seen;
    int bclk_seen;
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL sp_start: got %b want 1", frame_start); end
    capture(42);
    total++; if (cap_bits !== frame_word(24'h100003, 24'h200003)) begin bad++; $display("FAIL sp_bits: got %h want %h", cap_bits, frame_word(24'h100003, 24'h200003)); end
    total++; if (n_acc !== 5) begin bad++; $display("FAIL sp_accepts: got %0d want 5", n_acc); end
    tick();
    total++; if ({frame_start, bclk, lrclk, sdout} !== 4'b0000) begin bad++; $display("FAIL sp_idle: got %b want 0000", {frame_start, bclk, lrclk, sdout}); end
    fs_seen = 0; bclk_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      fs_seen += int'(frame_start);
      bclk_seen += int'(bclk);
    end
    total++; if (fs_seen + bclk_seen !== 0) begin bad++; $display("FAIL sp_quiet: fs %0d bclk %0d want 0 0", fs_seen, bclk_seen); end
    total++; if (in_ready !== 1'b0 || n_acc !== 5) begin bad++; $display("FAIL sp_held: in_ready %b accepts %0d want 0 5", in_ready, n_acc); end
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    total++; if ({frame_start, underrun} !== 2'b10) begin bad++; $display("FAIL sp_restart: got %b want 10", {frame_start, underrun}); end
    capture(-1);
    total++; if (cap_bits !== frame_word(24'h100004, 24'h200004)) begin bad++; $display("FAIL sp_resume_bits: got %h want %h", cap_bits, frame_word(24'h100004, 24'h200004)); end
    tick();
  endtask

  task automatic test_mid_reset();
    int waited;
    enable = 1'b1;
    tick();
    tick();
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL mr_start: got %b want 1", frame_start); end
    repeat (160) tick();
    total++; if (lrclk !== 1'b1 || n_acc !== 7) begin bad++; $display("FAIL mr_right_slot: lrclk %b accepts %0d want 1 7", lrclk, n_acc); end
    rst_n = 1'b0;
    #1;
    total++; if ({bclk, lrclk, sdout, in_ready, frame_start, underrun} !== 6'b000000) begin
      bad++; $display("FAIL mr_async: got %b want 000000", {bclk, lrclk, sdout, in_ready, frame_start, underrun});
    end
    stream_on = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    waited = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (frame_start === 1'b1) begin
        waited = i;
        break;
      end
    end
    total++; if (waited !== 2) begin bad++; $display("FAIL mr_restart_delay: got %0d want 2", waited); end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL mr_underrun: got %b want 1", underrun); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_underrun();
    test_streaming();
    test_stop();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
